bsg_clk_gen_pearl_tag_sequencer: RTL and testbench
==================================================

// Module: bsg_clk_gen_pearl_tag_sequencer
// PURPOSE
// - Synthesizable bsg_tag master for the clk_gen pearl: serializes configuration commands into bsg_tag packets on tag_data_o/tag_en_o.
// - Round-robin shares the single tag line between num_req_p requesters (e.g. sweep engine, host CSR).
// - Runs on the tag clock, upstream of the pearl; owns async_clk_gen_disable_o.
// PARAMETERS
// - els_p                 16   number of tag clients; id_width_lp = `BSG_SAFE_CLOG2(els_p)
// - max_payload_width_p   16   max payload bits; len_width_lp = `BSG_SAFE_CLOG2(max_payload_width_p+1)
// - num_req_p             2    requester ports
// - init_zeros_p          64   zero bits driven with tag_en_o=1 after reset, before any packet
// - gap_cycles_p          4    zero bits driven between packets (>=1)
// PORTS
// - clk_i                    in   1                tag clock
// - reset_n_i                in   1                async active-low reset
// - req_v_i                  in   num_req_p        command valid per requester
// - req_ready_o              out  num_req_p        command accepted this cycle (valid&ready handshake)
// - req_id_i                 in   num_req_p*id_w   target client id
// - req_data_not_reset_i     in   num_req_p        1=data packet, 0=client reset packet
// - req_len_i                in   num_req_p*len_w  payload length in bits, 1..max_payload_width_p
// - req_payload_i            in   num_req_p*max_pw payload, bit 0 sent first
// - tag_data_o               out  1                serial tag data
// - tag_en_o                 out  1                tag enable
// - async_clk_gen_disable_o  out  1                held 1 until init finished
// - busy_o                   out  1                packet or gap in progress
// BEHAVIOUR
// - Clock/reset: one clock (clk_i); reset_n_i asynchronous, active-low. All flops reset asynchronously.
// - Reset values: tag_data_o=0, tag_en_o=0, async_clk_gen_disable_o=1, req_ready_o=0, busy_o=0, rr pointer=0.
// - FSM: eINIT -> eIDLE -> eSEND -> eGAP -> eIDLE.
//   eINIT: tag_en_o=1, tag_data_o=0 for init_zeros_p cycles; on last cycle clear async_clk_gen_disable_o (low from first eIDLE cycle).
//   eIDLE: tag_en_o=1, data=0. Round-robin arbiter picks among req_v_i starting at pointer; winner gets req_ready_o=1 same cycle (combinational from req_v_i, FSM state). Fields latched into a shift register; next state eSEND. Pointer advances to winner+1 (mod num_req_p) on grant.
//   eSEND: shift packet LSB-first: start bit 1, len (len_w bits), data_not_reset (1), id (id_w), then payload bits 0..len-1. Total = 2+len_w+id_w+len cycles; bit counter down-counts, width sized for max packet.
//   eGAP: gap_cycles_p zero bits, then eIDLE.
// - Throughput: at most one grant per packet; req_ready_o=0 outside eIDLE. Grant-to-first-bit latency: 1 cycle (start bit in cycle after handshake).
// - Registered outputs: tag_data_o/tag_en_o are flops, no glitches.
// - Boundaries: len=0 or len>max_payload_width_p is illegal (assertion, nonsynth); payload bits above len ignored. Single requester asserting continuously is granted each eIDLE. Simultaneous requests: lowest index at/after pointer wins. Requester dropping valid without ready is allowed (no grant). Reset mid-packet: line returns to reset values immediately; packet discarded; full eINIT replays.
// - async_clk_gen_disable_o never reasserts except via reset.
// STRUCTURE
// - Package bsg_clk_gen_pearl_tag_pkg: state enum, packet header struct {len, data_not_reset, id} ordered for LSB-first shift, width localparam functions.
// - Sub-module: bsg_round_robin_arb (existing) for grant; the rest (FSM, counters, shifter) in this module.
// TESTING
// - Reset release -> exactly 64 cycles en=1,data=0; disable_o falls on cycle 65; no ready before.
// - Req0: id=3,dnr=1,len=8,payload=8'hA5 (els_p=16,max=16) -> 1,len LSB-first 0001 0,1,id 1100, payload 10100101; 19 bits then 4 zeros.
// - Req0 and req1 valid continuously -> grants alternate 0,1,0,1; no packet lost or repeated.
// - Reset packet: dnr=0,len=16,payload=16'hFFFF -> dnr bit 0, 16 ones; decoded by bsg_tag_master model into client reset.
// - reset_n_i pulsed mid-payload -> outputs to reset values same cycle; eINIT replays; pending req regranted.
// - End-to-end: drive bsg_clk_gen_pearl with trace of osc/ds/sel packets -> bsg_nonsynth_clk_watcher reports expected periods.

Source files
------------

// File: rtl/bsg_clk_gen_pearl_tag_pkg.sv
// rtl/bsg_clk_gen_pearl_tag_pkg.sv - shared states, width helpers and header layout for the tag sequencer
package bsg_clk_gen_pearl_tag_pkg;

  // Sequencer states
  localparam logic [1:0] e_init = 2'd0;
  localparam logic [1:0] e_idle = 2'd1;
  localparam logic [1:0] e_send = 2'd2;
  localparam logic [1:0] e_gap  = 2'd3;

  // Never returns 0 so a single-entry field still has one bit
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int default_els         = 16;
  localparam int default_max_payload = 16;
  localparam int default_id_w        = safe_clog2(default_els);
  localparam int default_len_w       = safe_clog2(default_max_payload + 1);

  // Header fields after the start bit; len sits at the LSB because it leaves the shifter first
  typedef struct packed {
    logic [default_id_w-1:0]  id;
    logic                     data_not_reset;
    logic [default_len_w-1:0] len;
  } header_t;

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_sequencer_if.sv
// rtl/bsg_clk_gen_pearl_tag_sequencer_if.sv - requester command bus into the tag sequencer
interface bsg_clk_gen_pearl_tag_sequencer_if #(
  parameter int num_req_p           = 2,
  parameter int id_width_p          = bsg_clk_gen_pearl_tag_pkg::default_id_w,
  parameter int len_width_p         = bsg_clk_gen_pearl_tag_pkg::default_len_w,
  parameter int max_payload_width_p = bsg_clk_gen_pearl_tag_pkg::default_max_payload
);

  logic [num_req_p-1:0]                          req_v;
  logic [num_req_p-1:0]                          req_ready;
  logic [num_req_p-1:0][id_width_p-1:0]          req_id;
  logic [num_req_p-1:0]                          req_data_not_reset;
  logic [num_req_p-1:0][len_width_p-1:0]         req_len;
  logic [num_req_p-1:0][max_payload_width_p-1:0] req_payload;

  modport master (
    output req_v, req_id, req_data_not_reset, req_len, req_payload,
    input  req_ready
  );

  modport slave (
    input  req_v, req_id, req_data_not_reset, req_len, req_payload,
    output req_ready
  );

endinterface

// File: rtl/bsg_round_robin_arb.sv
// rtl/bsg_round_robin_arb.sv - round-robin arbiter with pointer advancing past each winner
module bsg_round_robin_arb
  import bsg_clk_gen_pearl_tag_pkg::*;
#(
  parameter  int inputs_p     = 2,
  localparam int sel_width_lp = safe_clog2(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    grants_en_i,
  input  logic [inputs_p-1:0]     reqs_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic [sel_width_lp-1:0] sel_o,
  output logic                    v_o
);

  logic [sel_width_lp-1:0] ptr;

  // First requester found scanning upward from the pointer, wrapping at inputs_p
  always_comb begin
    grants_o = '0;
    sel_o    = '0;
    v_o      = 1'b0;
    for (int k = 0; k < inputs_p; k++) begin
      if (!v_o && reqs_i[(int'(ptr) + k) % inputs_p]) begin
        v_o   = 1'b1;
        sel_o = sel_width_lp'((int'(ptr) + k) % inputs_p);
      end
    end
    if (v_o && grants_en_i) grants_o[sel_o] = 1'b1;
  end

  // Pointer moves to the slot after the winner only when a grant is actually issued
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr <= '0;
    end else if (grants_en_i && v_o) begin
      ptr <= (sel_o == sel_width_lp'(inputs_p - 1)) ? '0 : sel_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_sequencer.sv
// rtl/bsg_clk_gen_pearl_tag_sequencer.sv - bsg_tag master serializing requester commands onto the tag line
module bsg_clk_gen_pearl_tag_sequencer
  import bsg_clk_gen_pearl_tag_pkg::*;
#(
  parameter  int els_p               = default_els,
  parameter  int max_payload_width_p = default_max_payload,
  parameter  int num_req_p           = 2,
  parameter  int init_zeros_p        = 64,
  parameter  int gap_cycles_p        = 4,
  localparam int id_width_lp         = safe_clog2(els_p),
  localparam int len_width_lp        = safe_clog2(max_payload_width_p + 1),
  localparam int sel_width_lp        = safe_clog2(num_req_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_clk_gen_pearl_tag_sequencer_if.slave req,
  output logic tag_data_o,
  output logic tag_en_o,
  output logic async_clk_gen_disable_o,
  output logic busy_o
);

  // Bits following the start bit: header then the widest possible payload
  localparam int hdr_bits_lp   = len_width_lp + 1 + id_width_lp;
  localparam int body_width_lp = hdr_bits_lp + max_payload_width_p;
  localparam int cnt_width_lp  = safe_clog2(max3(init_zeros_p, body_width_lp, gap_cycles_p) + 1);

  logic [1:0]                     state;
  logic [cnt_width_lp-1:0]        cnt;
  logic [body_width_lp-1:0]       shift;
  logic [num_req_p-1:0]           grants;
  logic [sel_width_lp-1:0]        sel;
  logic                           arb_v;
  logic                           idle;
  logic                           grant_v;
  logic [id_width_lp-1:0]         sel_id;
  logic                           sel_dnr;
  logic [len_width_lp-1:0]        sel_len;
  logic [max_payload_width_p-1:0] sel_payload;

  assign idle    = (state == e_idle);
  assign grant_v = arb_v & idle;
  assign busy_o  = (state == e_send) || (state == e_gap);

  bsg_round_robin_arb #(.inputs_p(num_req_p)) arb (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .grants_en_i (idle),
    .reqs_i      (req.req_v),
    .grants_o    (grants),
    .sel_o       (sel),
    .v_o         (arb_v)
  );

  assign req.req_ready = grants;
  assign sel_id        = req.req_id[sel];
  assign sel_dnr       = req.req_data_not_reset[sel];
  assign sel_len       = req.req_len[sel];
  assign sel_payload   = req.req_payload[sel];

  // Init zeros, grant/latch, LSB-first shift-out and inter-packet gap; outputs are flops
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                   <= e_init;
      cnt                     <= cnt_width_lp'(init_zeros_p);
      shift                   <= '0;
      tag_data_o              <= 1'b0;
      tag_en_o                <= 1'b0;
      async_clk_gen_disable_o <= 1'b1;
    end else begin
      tag_en_o <= 1'b1;
      case (state)
        e_init: begin
          if (cnt == '0) begin
            state                   <= e_idle;
            async_clk_gen_disable_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        e_idle: begin
          if (grant_v) begin
            state      <= e_send;
            tag_data_o <= 1'b1;
            shift      <= {sel_payload, sel_id, sel_dnr, sel_len};
            // Counts bits still to go after the start bit now on the line
            cnt        <= cnt_width_lp'(hdr_bits_lp) + cnt_width_lp'(sel_len);
          end
        end
        e_send: begin
          if (cnt == '0) begin
            state      <= e_gap;
            tag_data_o <= 1'b0;
            cnt        <= cnt_width_lp'(gap_cycles_p - 1);
          end else begin
            tag_data_o <= shift[0];
            shift      <= shift >> 1;
            cnt        <= cnt - 1'b1;
          end
        end
        e_gap: begin
          if (cnt == '0) state <= e_idle;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= e_init;
      endcase
    end
  end

  // Requesters must never offer an empty or oversized payload
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    grant_v |-> ((sel_len != '0) && (sel_len <= len_width_lp'(max_payload_width_p))));

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv
// tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv - scoreboard bench decoding the tag line against a reference model
module tb_bsg_clk_gen_pearl_tag_sequencer;

  localparam int ELS   = 16;
  localparam int MAXP  = 16;
  localparam int NREQ  = 2;
  localparam int INIT  = 64;
  localparam int GAP   = 4;
  localparam int ID_W  = $clog2(ELS);
  localparam int LEN_W = $clog2(MAXP + 1);
  localparam int HDR   = LEN_W + 1 + ID_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tag_data, tag_en, disable_o, busy;
  int   checks = 0;
  int   errors = 0;

  bsg_clk_gen_pearl_tag_sequencer_if #(
    .num_req_p(NREQ), .id_width_p(ID_W), .len_width_p(LEN_W), .max_payload_width_p(MAXP)
  ) rq ();

  bsg_clk_gen_pearl_tag_sequencer #(
    .els_p(ELS), .max_payload_width_p(MAXP), .num_req_p(NREQ),
    .init_zeros_p(INIT), .gap_cycles_p(GAP)
  ) dut (
    .clk_i                   (clk),
    .reset_n_i               (reset_n),
    .req                     (rq),
    .tag_data_o              (tag_data),
    .tag_en_o                (tag_en),
    .async_clk_gen_disable_o (disable_o),
    .busy_o                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int dnr;
    int len;
    int payload;
  } pkt_t;

  pkt_t exp_q[$];
  int   m_ptr = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: bsg_tag-style decoder plus round-robin reference for grant order
  int dec_phase = 0;
  int dec_idx   = 0;
  int dec_hdr   = 0;
  int d_len, d_dnr, d_id, d_pay;
  int zeros     = 0;
  bit seen      = 1'b0;

  task automatic finish_pkt();
    pkt_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pkt: got id=%0d len=%0d expected none", d_id, d_len);
    end else begin
      e = exp_q.pop_front();
      check("pkt_id", d_id, e.id);
      check("pkt_dnr", d_dnr, e.dnr);
      check("pkt_len", d_len, e.len);
      check("pkt_payload", d_pay, e.payload);
    end
    dec_phase = 0;
    zeros     = 0;
    seen      = 1'b1;
  endtask

  always @(negedge clk) begin
    int   win;
    int   exp_rdy;
    pkt_t p;
    if (!reset_n) begin
      exp_q.delete();
      m_ptr     = 0;
      dec_phase = 0;
      zeros     = 0;
      seen      = 1'b0;
    end else begin
      win     = -1;
      exp_rdy = 0;
      if (!disable_o && !busy) begin
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && rq.req_v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        if (win >= 0) exp_rdy = 1 << win;
      end
      check("ready_vector", int'(rq.req_ready), exp_rdy);
      if (win >= 0) begin
        p.id      = int'(rq.req_id[win]);
        p.dnr     = int'(rq.req_data_not_reset[win]);
        p.len     = int'(rq.req_len[win]);
        p.payload = int'(rq.req_payload[win]) & ((1 << p.len) - 1);
        exp_q.push_back(p);
        m_ptr = (win + 1) % NREQ;
      end
      if (!disable_o) check("tag_en_high", int'(tag_en), 1);
      if (tag_en) begin
        case (dec_phase)
          0: begin
            if (tag_data) begin
              if (seen) check("gap_zeros_min", (zeros >= GAP) ? 1 : 0, 1);
              dec_phase = 1;
              dec_idx   = 0;
              dec_hdr   = 0;
            end else begin
              zeros++;
            end
          end
          1: begin
            dec_hdr = dec_hdr | (int'(tag_data) << dec_idx);
            dec_idx++;
            if (dec_idx == HDR) begin
              d_len   = dec_hdr & ((1 << LEN_W) - 1);
              d_dnr   = (dec_hdr >> LEN_W) & 1;
              d_id    = (dec_hdr >> (LEN_W + 1)) & ((1 << ID_W) - 1);
              d_pay   = 0;
              dec_idx = 0;
              if (d_len < 1 || d_len > MAXP) finish_pkt();
              else dec_phase = 2;
            end
          end
          default: begin
            d_pay = d_pay | (int'(tag_data) << dec_idx);
            dec_idx++;
            if (dec_idx == d_len) finish_pkt();
          end
        endcase
      end
    end
  end

  // Stimulus helpers
  logic [NREQ-1:0] hs;

  task automatic set_req(input int i, input bit v, input int id, input int dnr, input int len, input int pay);
    rq.req_v[i]              = v;
    rq.req_id[i]             = ID_W'(id);
    rq.req_data_not_reset[i] = dnr[0];
    rq.req_len[i]            = LEN_W'(len);
    rq.req_payload[i]        = MAXP'(pay);
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'b1, $urandom_range(0, ELS - 1), $urandom_range(0, 1),
            $urandom_range(1, MAXP), $urandom_range(0, 65535));
  endtask

  task automatic step();
    @(negedge clk);
    hs = rq.req_v & rq.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic run_init();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= INIT; k++) begin
      @(negedge clk);
      check("init_en", int'(tag_en), 1);
      check("init_data", int'(tag_data), 0);
      check("init_disable", int'(disable_o), 1);
      check("init_ready", int'(rq.req_ready), 0);
    end
    @(negedge clk);
    check("disable_fall", int'(disable_o), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tag_en"}, int'(tag_en), 0);
    check({tag, "_tag_data"}, int'(tag_data), 0);
    check({tag, "_disable"}, int'(disable_o), 1);
    check({tag, "_ready"}, int'(rq.req_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] exp_bits;
    logic [18:0] got_bits;
    int last, ngr, n;

    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0, 1, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Directed packet pending across init: id=3, data, len=8, payload A5
    set_req(0, 1'b1, 3, 1, 8, 'hA5);
    run_init();
    check("first_grant", int'(rq.req_ready), 1);
    @(posedge clk);
    #1;
    rq.req_v[0] = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      got_bits[i] = tag_data;
    end
    exp_bits = {8'hA5, 4'd3, 1'b1, 5'd8, 1'b1};
    check("a5_stream", int'(got_bits), int'(exp_bits));
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      check("a5_gap_zero", int'(tag_data), 0);
    end

    // Both requesters held valid: grants must alternate
    rand_req(0);
    rand_req(1);
    last = -1;
    ngr  = 0;
    n    = 0;
    while (ngr < 8 && n < 600) begin
      step();
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          if (last >= 0) check("alternate", i, 1 - last);
          last = i;
          ngr++;
          rand_req(i);
        end
      end
    end
    check("alt_grant_count", ngr, 8);

    // Random traffic with valid dropping and re-raising
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          if ($urandom_range(0, 3) == 0) rq.req_v[i] = 1'b0;
          else rand_req(i);
        end else if (!rq.req_v[i]) begin
          if ($urandom_range(0, 7) == 0) rand_req(i);
        end else if ($urandom_range(0, 31) == 0) begin
          rq.req_v[i] = 1'b0;
        end
      end
    end

    // Client reset packet: dnr=0, 16 ones
    rq.req_v = '0;
    set_req(1, 1'b1, 5, 0, 16, 'hFFFF);
    n = 0;
    hs = '0;
    while (!hs[1] && n < 300) begin
      step();
      n++;
    end
    rq.req_v[1] = 1'b0;
    check("reset_pkt_granted", int'(hs[1]), 1);

    // Reset pulsed mid-payload: outputs return at once, init replays, pending req1 regranted
    set_req(0, 1'b1, 9, 1, 16, $urandom_range(0, 65535));
    n = 0;
    hs = '0;
    while (!hs[0] && n < 300) begin
      step();
      n++;
    end
    rq.req_v[0] = 1'b0;
    set_req(1, 1'b1, 7, 1, 4, 'h9);
    n = 0;
    while (!(dec_phase == 2 && dec_idx >= 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_payload", (n < 100) ? 1 : 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    run_init();
    check("regrant_req1", int'(rq.req_ready), 2);
    @(posedge clk);
    #1;
    rq.req_v[1] = 1'b0;

    // Drain: every granted packet must appear on the line
    n = 0;
    while ((exp_q.size() != 0 || dec_phase != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
